// File: rtl/countdown_pkg.sv
// Shared types and default sizes for the countdown timer and its bench.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } countdown_state_t;

  localparam int unsigned CD_WIDTH     = 8;
  localparam int unsigned CD_EXP_WIDTH = 8;

endpackage

// File: rtl/countdown.sv
// Loadable down-counter with one-shot/periodic expiry pulse and a saturating
// expiry tally. Load over valid/ready in IDLE; pause freezes, abort cancels.
module countdown
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH     = CD_WIDTH,
  parameter int unsigned EXP_WIDTH = CD_EXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [WIDTH-1:0]     load_value,
  input  logic                 auto_reload,
  input  logic                 pause,
  input  logic                 abort,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 expired,
  output logic [EXP_WIDTH-1:0] expire_total
);

  countdown_state_t state, state_next;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             mode_reg, mode_next;
  logic             fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      reload_reg   <= '0;
      mode_reg     <= 1'b0;
      expired      <= 1'b0;
      expire_total <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      mode_reg   <= mode_next;
      expired    <= fire;
      if (fire && (expire_total != '1)) begin
        expire_total <= expire_total + EXP_WIDTH'(1);
      end
    end
  end

  // Priority inside the active states: abort, then pause, then decrement/expire.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload_reg;
    mode_next   = mode_reg;
    fire        = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_valid) begin
          count_next  = load_value;
          reload_next = load_value;
          mode_next   = auto_reload;
          if (load_value == '0) begin
            fire = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
        end else if (pause) begin
          state_next = HOLD;
        end else if (count > WIDTH'(1)) begin
          count_next = count - WIDTH'(1);
        end else begin
          fire = 1'b1;
          if (mode_reg) begin
            count_next = reload_reg;
          end else begin
            count_next = '0;
            state_next = IDLE;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
        end else if (!pause) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_countdown.sv
// Scoreboard bench for countdown: two instances (tally widths 8 and 2) share
// stimulus; a behavioural model predicts every cycle and every expiry pulse.
module tb_countdown;
  import countdown_pkg::*;

  localparam int unsigned W = CD_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load_valid = 1'b0;
  logic         auto_reload = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] load_value = '0;

  logic [W-1:0] count8, count2;
  logic         ready8, ready2, busy8, busy2, exp8, exp2;
  logic [7:0]   tot8;
  logic [1:0]   tot2;

  countdown #(.WIDTH(W), .EXP_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready8),
    .load_value(load_value), .auto_reload(auto_reload), .pause(pause),
    .abort(abort), .count(count8), .busy(busy8), .expired(exp8),
    .expire_total(tot8)
  );

  countdown #(.WIDTH(W), .EXP_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(ready2),
    .load_value(load_value), .auto_reload(auto_reload), .pause(pause),
    .abort(abort), .count(count2), .busy(busy2), .expired(exp2),
    .expire_total(tot2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit busy;
    bit ready;
    bit exp;
    int t8;
    int t2;
  } snap_t;

  typedef struct {
    int cyc;
    int t8;
    int t2;
  } pulse_t;

  snap_t  snap_q[$];
  pulse_t pulse_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: timer described as remaining ticks plus activity flags.
  bit m_active, m_held, m_periodic, m_exp;
  int m_cnt, m_reload, m_t8, m_t2;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fire();
    m_exp = 1'b1;
    if (m_t8 < 255) m_t8++;
    if (m_t2 < 3) m_t2++;
  endtask

  task automatic model_edge();
    m_exp = 1'b0;
    if (!rst_n) begin
      m_active = 0; m_held = 0; m_periodic = 0;
      m_cnt = 0; m_reload = 0; m_t8 = 0; m_t2 = 0;
    end else if (!m_active) begin
      if (load_valid) begin
        m_cnt      = int'(load_value);
        m_reload   = int'(load_value);
        m_periodic = auto_reload;
        if (m_cnt == 0) fire();
        else m_active = 1;
      end
    end else if (abort) begin
      m_active = 0; m_held = 0; m_cnt = 0;
    end else if (m_held) begin
      if (!pause) m_held = 0;
    end else if (pause) begin
      m_held = 1;
    end else if (m_cnt > 1) begin
      m_cnt--;
    end else begin
      fire();
      if (m_periodic) m_cnt = m_reload;
      else begin m_cnt = 0; m_active = 0; end
    end
    snap_q.push_back('{m_cnt, m_active, !m_active, m_exp, m_t8, m_t2});
    if (m_exp) pulse_q.push_back('{cyc, m_t8, m_t2});
  endtask

  task automatic step(input bit r, input bit lv, input int v, input bit ar,
                      input bit p, input bit ab);
    @(negedge clk);
    rst_n = r; load_valid = lv; load_value = W'(v);
    auto_reload = ar; pause = p; abort = ab;
    @(posedge clk);
    #1 model_edge();
  endtask

  task automatic run(input int n, input bit r, input bit lv, input int v,
                     input bit ar, input bit p, input bit ab);
    for (int i = 0; i < n; i++) step(r, lv, v, ar, p, ab);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    load_valid = 1'b0; pause = 1'b0; abort = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", count8, 0);
    check("rst_busy", busy8, 0);
    check("rst_ready", ready8, 1);
    check("rst_expired", exp8, 0);
    check("rst_total8", tot8, 0);
    check("rst_total2", tot2, 0);
    @(posedge clk);
    #1 model_edge();
  endtask

  // Monitor: per-cycle state from the snapshot queue, pulses from the pulse queue.
  initial begin
    snap_t  s;
    pulse_t pl;
    forever begin
      @(negedge clk);
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        check("count", count8, s.cnt);
        check("busy", busy8, int'(s.busy));
        check("load_ready", ready8, int'(s.ready));
        check("expired", exp8, int'(s.exp));
        check("expire_total8", tot8, s.t8);
        check("count_w2", count2, s.cnt);
        check("expired_w2", exp2, int'(s.exp));
        check("expire_total2", tot2, s.t2);
      end
      if (exp8 === 1'b1) begin
        if (pulse_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pulse: unexpected expired at cycle %0d, none predicted", cyc);
        end else begin
          pl = pulse_q.pop_front();
          check("pulse_cycle", cyc, pl.cyc);
          check("pulse_total8", tot8, pl.t8);
          check("pulse_total2", tot2, pl.t2);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    run(3, 0, 0, 0, 0, 0, 0);
    run(1, 1, 0, 0, 0, 0, 0);
    // one-shot 5
    run(1, 1, 1, 5, 0, 0, 0);
    run(7, 1, 0, 0, 0, 0, 0);
    // periodic 3
    run(1, 1, 1, 3, 1, 0, 0);
    run(10, 1, 0, 0, 0, 0, 0);
    run(1, 1, 0, 0, 0, 0, 1);
    // load 4, pause at count 2 while a rejected load is presented
    run(1, 1, 1, 4, 0, 0, 0);
    run(2, 1, 0, 0, 0, 0, 0);
    run(2, 1, 1, 9, 0, 1, 0);
    run(4, 1, 0, 0, 0, 0, 0);
    // abort beats pause at count 1, then a zero load
    run(1, 1, 1, 2, 0, 0, 0);
    run(1, 1, 0, 0, 0, 0, 0);
    run(1, 1, 0, 0, 0, 1, 1);
    run(1, 1, 1, 0, 1, 0, 0);
    run(2, 1, 0, 0, 0, 0, 0);
    // asynchronous reset at count 7
    run(1, 1, 1, 10, 0, 0, 0);
    run(3, 1, 0, 0, 0, 0, 0);
    async_reset_check();
    run(2, 0, 0, 0, 0, 0, 0);
    run(1, 1, 0, 0, 0, 0, 0);
    // periodic 1: pulse every cycle, narrow tally saturates
    run(1, 1, 1, 1, 1, 0, 0);
    run(6, 1, 0, 0, 0, 0, 0);
    run(1, 1, 0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'b1, $urandom_range(0, 3) == 0, int'($urandom_range(0, 12)),
           1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
    end
    run(2, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5 && snap_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("pending_snapshots", snap_q.size(), 0);
    check("pending_pulses", pulse_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
